// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
//
// Purpose : memory-request bundle between the MEM stage of the MIPS32
//           pipeline (master) and the data-memory responder (slave).
//
// Signals : MemRead   master->slave  load request
//           MemWrite  master->slave  store request
//           Addr      master->slave  32-bit byte address
//           WriteData master->slave  32-bit store data
//           ReadData  slave->master  32-bit load data
//           MemStall  slave->master  freeze request to the hazard unit
//           MemReady  slave->master  access completes this cycle
//           AddrErr   slave->master  misaligned-access flag
// ---------------------------------------------------------------------------
interface dmem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MemStall;
    logic        MemReady;
    logic        AddrErr;

    modport master (
        output MemRead, MemWrite, Addr, WriteData,
        input  ReadData, MemStall, MemReady, AddrErr
    );

    modport slave (
        input  MemRead, MemWrite, Addr, WriteData,
        output ReadData, MemStall, MemReady, AddrErr
    );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Purpose : data-memory responder for the MEM stage. Serves load/store
//           requests from a word-addressed internal array and inserts
//           WAIT_STATES stall cycles per access, followed by one DONE cycle.
//
// Parameters : DEPTH_LOG2   log2 of array depth in 32-bit words
//              WAIT_STATES  stall cycles per access (1..15)
//
// Ports : clock  rising-edge clock
//         reset  asynchronous, active-low reset
//         bus    dmem_responder_if.slave (MemRead, MemWrite, Addr, WriteData
//                in; ReadData, MemStall, MemReady, AddrErr out)
//
// Build option : define DMEM_ALIGN_CHECK_EN to flag accesses with
//                Addr[1:0] != 0 on AddrErr (DONE cycle only), suppressing
//                the write or leaving ReadData unchanged. Without it AddrErr
//                is tied to 0 and Addr[1:0] is ignored.
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              cnt;
    logic [3:0]              cnt_next;

    // Request captured at acceptance; the rest of the access uses only these.
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic                    write_q;
    logic                    mis_q;

    logic [31:0]             rdata_q;
    logic                    addr_err_q;

    logic                    req;
    logic                    write_live;
    logic [DEPTH_LOG2-1:0]   idx_live;
    logic                    mis_live;
    logic                    accept;
    logic                    enter_done;

    // Values steering the ReadData capture: on a one-wait-state build DONE is
    // entered straight from IDLE, before the latched copies exist.
    logic [DEPTH_LOG2-1:0]   cur_idx;
    logic                    cur_read;
    logic                    cur_mis;

    logic [31:0]             mem [DEPTH];

    // Upper address bits wrap and the byte offset is ignored when unchecked.
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^{bus.Addr[31:DEPTH_LOG2+2], bus.Addr[1:0]};

    assign req        = bus.MemRead | bus.MemWrite;
    assign write_live = bus.MemWrite;   // read+write together counts as a write
    assign idx_live   = bus.Addr[DEPTH_LOG2+1:2];
    assign accept     = (state == S_IDLE) && req;

`ifdef DMEM_ALIGN_CHECK_EN
    assign mis_live = |bus.Addr[1:0];
`else
    assign mis_live = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            S_IDLE: begin
                if (req) begin
                    cnt_next   = 4'(WAIT_STATES - 1);
                    state_next = (WAIT_STATES == 1) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign enter_done = (state_next == S_DONE) && (state != S_DONE);
    assign cur_idx    = (state == S_IDLE) ? idx_live : idx_q;
    assign cur_read   = (state == S_IDLE) ? ~write_live : ~write_q;
    assign cur_mis    = (state == S_IDLE) ? mis_live : mis_q;

    // ------------------------------------------------------------------
    // State register and request capture
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state      <= S_IDLE;
            cnt        <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            write_q    <= 1'b0;
            mis_q      <= 1'b0;
            rdata_q    <= 32'd0;
            addr_err_q <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            addr_err_q <= enter_done && cur_mis;
            if (accept) begin
                idx_q   <= idx_live;
                wdata_q <= bus.WriteData;
                write_q <= write_live;
                mis_q   <= mis_live;
            end
            if (enter_done && cur_read && !cur_mis) begin
                rdata_q <= mem[cur_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage array: written on the edge leaving DONE. A reset during the
    // access forces IDLE first, so a pending write never lands.
    // ------------------------------------------------------------------
    // NOTE: the array is deliberately not reset; it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (state == S_DONE && write_q && !mis_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Stall is gated by reset so it drops the moment reset is asserted.
    assign bus.MemStall = reset && ((state == S_WAIT) || accept);
    assign bus.MemReady = (state == S_DONE);
    assign bus.ReadData = rdata_q;

`ifdef DMEM_ALIGN_CHECK_EN
    assign bus.AddrErr = addr_err_q;
`else
    assign bus.AddrErr = 1'b0;
`endif

endmodule
